// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared types and constants for the bit-serial subtractor.
// Holds the FSM state encoding and the default operand width.
package serial_sub_pkg;

   localparam int W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } sub_state_t;

endpackage

// File: rtl/serial_sub_if.sv
// serial_sub_if: start/done handshake and operand/result bus.
// master drives start/a/b; slave returns busy/done/diff/bout.
interface serial_sub_if
   import serial_sub_pkg::*;
#(
   parameter int W = W_DEF
);

   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         bout;

   modport master (
      output start, a, b,
      input  busy, done, diff, bout
   );

   modport slave (
      input  start, a, b,
      output busy, done, diff, bout
   );

endinterface

// File: rtl/serial_sub_full_sub.sv
// full_sub: combinational 1-bit full subtractor cell.
// Ports: a, b, bin in; d (difference), bo (borrow out) out.
module full_sub (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bo
);

   assign d  = a ^ b ^ bin;
   assign bo = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// serial_sub: bit-serial unsigned a - b, LSB first, one bit per clock.
// Ports: clk, rst (sync, active-high); io slave: start,a,b -> busy,done,diff,bout.
module serial_sub
   import serial_sub_pkg::*;
#(
   parameter int W = W_DEF
) (
   input logic        clk,
   input logic        rst,
   serial_sub_if.slave io
);

   localparam int CW = $clog2(W);

   sub_state_t   state;
   sub_state_t   nxt;
   logic [W-1:0] ra;
   logic [W-1:0] rb;
   logic [W-1:0] rd;
   logic         brw;
   logic [CW-1:0] cnt;
   logic         last;
   logic         d;
   logic         bo;

   assign last = (cnt == CW'(W - 1));

   full_sub u_cell (
      .a   (ra[0]),
      .b   (rb[0]),
      .bin (brw),
      .d   (d),
      .bo  (bo)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nxt;
      end
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:    if (io.start) nxt = SHIFT;
         SHIFT:   if (last) nxt = DONE;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ra  <= '0;
         rb  <= '0;
         rd  <= '0;
         brw <= 1'b0;
         cnt <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (io.start) begin
                  ra  <= io.a;
                  rb  <= io.b;
                  brw <= 1'b0;
                  cnt <= '0;
               end
            end
            SHIFT: begin
               ra  <= ra >> 1;
               rb  <= rb >> 1;
               // result enters at the MSB; W shifts align bit 0
               rd  <= {d, rd[W-1:1]};
               brw <= bo;
               // hold on the final bit so the counter never wraps
               if (!last) cnt <= cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

   assign io.busy = (state != IDLE);
   assign io.done = (state == DONE);
   assign io.diff = rd;
   assign io.bout = brw;

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: randomized check of serial_sub against a - b arithmetic.
// Covers reset, latency, boundaries, start-held throughput, mid-op reset.
module tb_serial_sub;

   localparam int W = 8;
   localparam int P = W + 2;

   logic clk;
   logic rst;
   int   nvec;
   int   nerr;

   serial_sub_if #(.W(W)) sif ();

   serial_sub #(.W(W)) dut (
      .clk (clk),
      .rst (rst),
      .io  (sif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] mdiff(input int x, input int y);
      int r;
      r = (x - y) % (1 << W);
      if (r < 0) r += (1 << W);
      return W'(r);
   endfunction

   task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y);
      int k;
      @(negedge clk);
      sif.start = 1'b1;
      sif.a     = x;
      sif.b     = y;
      @(posedge clk);
      #1;
      sif.start = 1'b0;
      sif.a     = W'($urandom);
      sif.b     = W'($urandom);
      chk("busy_rise", 32'(sif.busy), 32'd1);
      k = 0;
      while (k < 3 * W) begin
         @(posedge clk);
         #1;
         k++;
         if (sif.done) break;
      end
      chk("lat", k, W);
      chk("diff", 32'(sif.diff), 32'(mdiff(int'(x), int'(y))));
      chk("bout", 32'(sif.bout), 32'(x < y));
      @(posedge clk);
      #1;
      chk("done_pulse", 32'(sif.done), 32'd0);
      chk("busy_fall", 32'(sif.busy), 32'd0);
      chk("diff_hold", 32'(sif.diff), 32'(mdiff(int'(x), int'(y))));
   endtask

   initial begin
      logic [W-1:0] qa[$];
      logic [W-1:0] qb[$];
      int seen;
      nvec = 0;
      nerr = 0;
      rst = 1'b1;
      sif.start = 1'b0;
      sif.a = '0;
      sif.b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(sif.busy), 32'd0);
      chk("rst_done", 32'(sif.done), 32'd0);
      chk("rst_diff", 32'(sif.diff), 32'd0);
      chk("rst_bout", 32'(sif.bout), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      do_op(8'd200, 8'd55);
      do_op(8'd5, 8'd10);
      do_op(8'd0, 8'd255);
      do_op(8'd255, 8'd255);
      do_op(8'd0, 8'd0);

      // start held high, operands changing every cycle
      for (int e = 0; e < 3 * P; e++) begin
         @(negedge clk);
         sif.start = 1'b1;
         if (e == 0) begin
            sif.a = 8'd100;
            sif.b = 8'd1;
         end else begin
            sif.a = W'($urandom);
            sif.b = W'($urandom);
         end
         qa.push_back(sif.a);
         qb.push_back(sif.b);
         @(posedge clk);
         #1;
         chk("hold_busy", 32'(sif.busy), 32'((e % P) <= W));
         chk("hold_done", 32'(sif.done), 32'((e % P) == W));
         if ((e % P) == W) begin
            chk("hold_diff", 32'(sif.diff),
                32'(mdiff(int'(qa[e - W]), int'(qb[e - W]))));
            chk("hold_bout", 32'(sif.bout),
                32'(qa[e - W] < qb[e - W]));
         end
      end
      @(negedge clk);
      sif.start = 1'b0;

      // reset during the 4th SHIFT cycle
      do_op(8'd3, 8'd9);
      @(negedge clk);
      sif.start = 1'b1;
      sif.a = 8'd77;
      sif.b = 8'd12;
      @(posedge clk);
      #1;
      sif.start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_busy", 32'(sif.busy), 32'd0);
      chk("abort_diff", 32'(sif.diff), 32'd0);
      chk("abort_bout", 32'(sif.bout), 32'd0);
      chk("abort_done", 32'(sif.done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (2 * P) begin
         @(posedge clk);
         #1;
         if (sif.done) seen++;
      end
      chk("abort_nodone", seen, 0);

      for (int i = 0; i < 1000; i++) begin
         do_op(W'($urandom), W'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
